// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM states, queue entry layout, default sizes.
package ifq_pkg;
  localparam int IFQ_XLEN  = 32;
  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_PTR_W = $clog2(IFQ_DEPTH);

  typedef enum logic {FETCH, DRAIN} ifq_state_e;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] data;
    logic [IFQ_XLEN-1:0] pc;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO of {data, pc} entries; flush wins over push/pop.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  ifq_entry_t       din,
  input  logic             pop,
  input  logic             flush,
  output ifq_entry_t       dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             rd;

  assign rd    = pop && !empty;
  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(rd);
    end
  end

  // Storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge clk) begin
    if (!flush && push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: PC, credit-limited imem requests, redirect flush/drain, prefetch queue.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int              XLEN     = IFQ_XLEN,
  parameter int              DEPTH    = IFQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pcplus4
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 2;

  ifq_state_e      state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, rsp_pc, rsp_pc_nx, base, tgt, addr_nx;
  logic [CW-1:0]   outst, outst_nx, drop, drop_nx, count_nx;
  logic [PTR_W:0]  count;
  logic            full, empty, accept, hold, byp, push, wr, pop, req_nx;
  ifq_entry_t      head, rsp_entry, cur;

  assign tgt       = redirect_pc & ~XLEN'(3);
  assign accept    = imem_req_valid && imem_req_ready;
  assign hold      = imem_req_valid && !imem_req_ready;
  assign rsp_entry = '{data: imem_rsp_data, pc: rsp_pc};

`ifdef IFQ_BYPASS_EN
  assign byp = empty && (state == FETCH) && !redirect_valid && imem_rsp_valid;
`else
  assign byp = 1'b0;
`endif

  assign push     = (state == FETCH) && !redirect_valid && imem_rsp_valid && !(byp && inst_ready);
  assign pop      = !empty && inst_ready && !redirect_valid;
  assign wr       = push && (!full || pop);
  assign outst_nx = outst + CW'(accept) - CW'(imem_rsp_valid);
  assign count_nx = redirect_valid ? '0 : CW'(count) + CW'(wr) - CW'(pop);

  always_comb begin
    state_nx  = state;
    drop_nx   = drop;
    rsp_pc_nx = rsp_pc;
    base      = redirect_valid ? tgt : pc;
    if (redirect_valid)                              rsp_pc_nx = tgt;
    else if (state == FETCH && imem_rsp_valid)       rsp_pc_nx = rsp_pc + XLEN'(4);
    case (state)
      FETCH: if (redirect_valid) begin
        drop_nx = outst_nx;
        // A held stale request must also be drained even if nothing is in flight yet.
        if (outst_nx != '0 || hold) state_nx = DRAIN;
      end
      DRAIN: begin
        drop_nx = drop + CW'(accept) - CW'(imem_rsp_valid);
        if (drop_nx == '0 && !hold) state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
    req_nx  = hold || (state_nx == FETCH && (count_nx + outst_nx) < CW'(DEPTH));
    addr_nx = hold ? imem_req_addr : base;
    pc_nx   = (req_nx && !hold) ? base + XLEN'(4) : base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      rsp_pc         <= RESET_PC;
      outst          <= '0;
      drop           <= '0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= '0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      rsp_pc         <= rsp_pc_nx;
      outst          <= outst_nx;
      drop           <= drop_nx;
      imem_req_valid <= req_nx;
      imem_req_addr  <= addr_nx;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .din   (rsp_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    cur = head;
    if (empty) cur = byp ? rsp_entry : '0;
  end

  assign inst_valid   = !empty || byp;
  assign inst_data    = cur.data;
  assign inst_pc      = cur.pc;
  assign inst_pcplus4 = inst_valid ? cur.pc + XLEN'(4) : '0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model with epoch tags for redirect drops.
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 0, reset = 0;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        inst_valid, inst_ready = 0;
  logic [31:0] inst_data, inst_pc, inst_pcplus4;

  ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pcplus4(inst_pcplus4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t        inflight[$];
  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, epoch = 0, lat = 1, n_cons = 0;
  logic        rdy_k = 0, ird_k = 0;
  logic        pend_v = 0;
  int          pend_tag = 0;
  logic [31:0] pend_addr = 0, exp_req = 0, first_pc = 0;
  logic        want_first = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input logic redir, input logic [31:0] tgt);
    logic rsp_now, exp_iv;
    req_t r;
    exp_t e;
    int   old_cnt;
    @(negedge clk);
    cyc++;
    imem_req_ready = rdy_k;
    inst_ready     = ird_k;
    redirect_valid = redir;
    redirect_pc    = tgt;
    rsp_now        = inflight.size() > 0 && inflight[0].due <= cyc;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? inflight[0].data : 32'h0;
    #1;
    exp_iv = sb.size() > 0;
`ifdef IFQ_BYPASS_EN
    if (rsp_now && !redir && inflight[0].epoch == epoch) exp_iv = 1'b1;
`endif
    chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (rsp_now) begin
      r = inflight.pop_front();
      if (!redir && r.epoch == epoch) sb.push_back('{pc: r.addr, data: r.data});
    end
    if (inst_valid && inst_ready && !redir) begin
      if (sb.size() == 0) chk("unexpected_inst", inst_pc, 32'hDEAD_BEEF);
      else begin
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_data", inst_data, e.data);
        chk("inst_pcplus4", inst_pcplus4, e.pc + 32'd4);
        n_cons++;
        if (want_first) begin first_pc = e.pc; want_first = 0; end
      end
    end
    if (imem_req_valid) begin
      if (pend_v) chk("req_hold", imem_req_addr, pend_addr);
      else begin pend_v = 1; pend_tag = epoch; pend_addr = imem_req_addr; end
    end
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      if (pend_tag == epoch) begin
        old_cnt = 0;
        foreach (inflight[i]) if (inflight[i].epoch != epoch) old_cnt++;
        chk("drain_done", 32'(old_cnt), 32'd0);
        chk("req_addr", imem_req_addr, exp_req);
        r.addr = exp_req;
        exp_req += 32'd4;
      end
      r.data  = mem_word(r.addr);
      r.epoch = pend_tag;
      r.due   = cyc + lat;
      inflight.push_back(r);
      pend_v = 0;
    end
    if (redir) begin
      sb.delete();
      epoch++;
      exp_req = tgt & ~32'd3;
      want_first = 1;
    end
    if (sb.size() + inflight.size() + int'(pend_v) > DEPTH)
      chk("credit", 32'(sb.size() + inflight.size() + int'(pend_v)), DEPTH);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_pcplus4", inst_pcplus4, 0);
    reset = 1;

    // streaming, 1-cycle latency
    lat = 1; rdy_k = 1; ird_k = 1; exp_req = 32'h0;
    run(10);
    n_cons = 0;
    run(10);
    chk("throughput", 32'(n_cons), 32'd10);

    // decode stall fills the queue
    ird_k = 0;
    run(10);
    chk("stall_entries", 32'(sb.size()), DEPTH);
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_inflight", 32'(inflight.size()), 0);
    ird_k = 1;
    run(10);

    // redirect with 3 outstanding, latency 3
    lat = 3;
    for (int i = 0; i < 12 && inflight.size() < 3; i++) step(1'b0, 32'h0);
    chk("pre_redir_outst", 32'(inflight.size() >= 3), 1);
    step(1'b1, 32'h100);
    run(15);
    chk("redir_first_pc", first_pc, 32'h100);

    // redirect with response and dequeue in the same cycle, misaligned target
    lat = 1;
    run(6);
    chk("redir_rsp_cycle", 32'(inflight.size() > 0 && sb.size() > 0), 1);
    step(1'b1, 32'h202);
    step(1'b0, 32'h0);
    chk("post_redir_iv", 32'(inst_valid), 0);
    run(10);
    chk("misalign_first_pc", first_pc, 32'h200);

    // redirect while a request is held
    rdy_k = 0;
    run(3);
    chk("held_valid", 32'(imem_req_valid), 1);
    step(1'b1, 32'h300);
    run(2);
    rdy_k = 1;
    run(12);
    chk("held_first_pc", first_pc, 32'h300);

    // 32-bit wrap of PC and PC+4
    step(1'b1, 32'hFFFF_FFF8);
    run(12);
    chk("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

    // reset while draining
    lat = 3;
    run(6);
    step(1'b1, 32'h400);
    step(1'b0, 32'h0);
    @(posedge clk); #2;
    reset = 0; imem_rsp_valid = 0; redirect_valid = 0;
    #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 0);
    chk("mid_rst_inst_valid", 32'(inst_valid), 0);
    chk("mid_rst_inst_data", inst_data, 0);
    chk("mid_rst_inst_pc", inst_pc, 0);
    chk("mid_rst_pcplus4", inst_pcplus4, 0);
    inflight.delete(); sb.delete(); pend_v = 0;
    epoch++; exp_req = 32'h0; want_first = 1;
    @(negedge clk); reset = 1;
    lat = 1;
    run(10);
    chk("post_rst_first_pc", first_pc, 32'h0);

    // stop fetching and drain everything
    rdy_k = 0;
    run(12);
    chk("final_sb", 32'(sb.size()), 0);
    chk("final_inflight", 32'(inflight.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
